// File: rtl/chip_shiftreg_tester.sv
// ---------------------------------------------------------------------------
// chip_shiftreg_tester
//
// Exhaustive functional tester for 74195-style parallel-access shift
// registers (J/Kn serial input, parallel load, direct clear, complemented
// last-stage output), generalised to WIDTH stages. Every (WIDTH+5)-bit
// vector is driven into the socket. After SETTLE_CYC cycles the DUT outputs
// are compared against an internal golden model.
//
// Ports
//   Clk          system clock
//   Reset        asynchronous, active-low reset
//   Run          start request, sampled only in IDLE
//   DISP_RSLT    result acknowledge; DONE -> IDLE
//   Dut_Q        DUT parallel outputs (Dut_Q[0] = first stage)
//   Dut_QnLast   DUT complemented last-stage output
//   Dut_CCLK, Dut_CLRn, Dut_SHLD, Dut_J, Dut_Kn, Dut_D  DUT control/data pins
//   Done         high while in DONE
//   RSLT         1 = every vector matched
//   Err_count    number of mismatching vectors, saturating
//   Fail_valid   first failure has been captured
//   Fail_vec     first failing vector
//   E            golden-model Q (captured expectation once Fail_valid)
//   Dbg_state    current FSM state, for observation only
//
// Handshake: Run is a level request that is only looked at in IDLE; a sweep
// then runs to completion regardless of Run. Done acts as "result valid"
// and stays high, with RSLT/Err_count/Fail_* stable, until DISP_RSLT is
// seen high on a clock edge. That edge returns the FSM to IDLE.
// ---------------------------------------------------------------------------
module chip_shiftreg_tester #(
   parameter int WIDTH      = 4,
   parameter int SETTLE_CYC = 2,
   parameter int ERR_W      = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Run,
   input  logic               DISP_RSLT,
   input  logic [WIDTH-1:0]   Dut_Q,
   input  logic               Dut_QnLast,
   output logic               Dut_CCLK,
   output logic               Dut_CLRn,
   output logic               Dut_SHLD,
   output logic               Dut_J,
   output logic               Dut_Kn,
   output logic [WIDTH-1:0]   Dut_D,
   output logic               Done,
   output logic               RSLT,
   output logic [ERR_W-1:0]   Err_count,
   output logic               Fail_valid,
   output logic [WIDTH+4:0]   Fail_vec,
   output logic [WIDTH-1:0]   E,
   output logic [2:0]         Dbg_state
);

   localparam int VW = WIDTH + 5;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_DRIVE  = 3'd2,
      S_SETTLE = 3'd3,
      S_CHECK  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t            state;
   logic [VW-1:0]     vec;
   logic [WIDTH-1:0]  model_q;
   logic [WIDTH-1:0]  fail_e;
   logic [SW-1:0]     settle_cnt;

   // Pin values decoded from the current vector. Active-low pins are
   // inverted so that vector 0 is "no clear, shift mode, hold".
   logic              v_cclk, v_clrn, v_shld, v_j, v_kn;
   logic [WIDTH-1:0]  v_d;
   logic              first_nxt;
   logic [WIDTH-1:0]  model_nxt;
   logic              mismatch;

   always_comb begin
      v_cclk = vec[0];
      v_d    = vec[WIDTH:1];
      v_shld = ~vec[WIDTH+1];
      v_j    = vec[WIDTH+2];
      v_kn   = ~vec[WIDTH+3];
      v_clrn = ~vec[WIDTH+4];

      // First-stage input from J/Kn: 00 clear, 11 set, 01 hold, 10 toggle.
      first_nxt = 1'b0;
      case ({v_j, v_kn})
         2'b00:   first_nxt = 1'b0;
         2'b11:   first_nxt = 1'b1;
         2'b01:   first_nxt = model_q[0];
         default: first_nxt = ~model_q[0];
      endcase

      // The previous vector's CCLK is still on the Dut_CCLK pin, so a
      // rising clock is "new CCLK high while the pin is still low".
      model_nxt = model_q;
      if (!v_clrn)
         model_nxt = '0;
      else if (v_cclk && !Dut_CCLK) begin
         if (!v_shld)
            model_nxt = v_d;
         else
            model_nxt = {model_q[WIDTH-2:0], first_nxt};
      end

      mismatch = ({Dut_Q, Dut_QnLast} != {model_q, ~model_q[WIDTH-1]});
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= S_IDLE;
         vec        <= '0;
         model_q    <= '0;
         fail_e     <= '0;
         settle_cnt <= '0;
         Dut_CCLK   <= 1'b0;
         Dut_CLRn   <= 1'b0;
         Dut_SHLD   <= 1'b0;
         Dut_J      <= 1'b0;
         Dut_Kn     <= 1'b0;
         Dut_D      <= '0;
         Done       <= 1'b0;
         RSLT       <= 1'b0;
         Err_count  <= '0;
         Fail_valid <= 1'b0;
         Fail_vec   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Run)
                  state <= S_INIT;
            end

            S_INIT: begin
               Dut_CCLK   <= 1'b0;
               Dut_CLRn   <= 1'b0;
               Dut_SHLD   <= 1'b0;
               Dut_J      <= 1'b0;
               Dut_Kn     <= 1'b0;
               Dut_D      <= '0;
               vec        <= '0;
               model_q    <= '0;
               fail_e     <= '0;
               Err_count  <= '0;
               Fail_valid <= 1'b0;
               Fail_vec   <= '0;
               RSLT       <= 1'b1;
               state      <= S_DRIVE;
            end

            S_DRIVE: begin
               Dut_CCLK   <= v_cclk;
               Dut_CLRn   <= v_clrn;
               Dut_SHLD   <= v_shld;
               Dut_J      <= v_j;
               Dut_Kn     <= v_kn;
               Dut_D      <= v_d;
               model_q    <= model_nxt;
               settle_cnt <= '0;
               state      <= S_SETTLE;
            end

            S_SETTLE: begin
               if (settle_cnt == SETTLE_LAST)
                  state <= S_CHECK;
               else
                  settle_cnt <= settle_cnt + 1'b1;
            end

            S_CHECK: begin
               if (mismatch) begin
                  RSLT <= 1'b0;
                  if (Err_count != {ERR_W{1'b1}})
                     Err_count <= Err_count + 1'b1;
                  if (!Fail_valid) begin
                     Fail_valid <= 1'b1;
                     Fail_vec   <= vec;
                     fail_e     <= model_q;
                  end
               end
               if (&vec) begin
                  Dut_CCLK <= 1'b0;
                  Dut_CLRn <= 1'b0;
                  Dut_SHLD <= 1'b0;
                  Dut_J    <= 1'b0;
                  Dut_Kn   <= 1'b0;
                  Dut_D    <= '0;
                  Done     <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  vec   <= vec + 1'b1;
                  state <= S_DRIVE;
               end
            end

            S_DONE: begin
               if (DISP_RSLT) begin
                  Done  <= 1'b0;
                  state <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign E         = Fail_valid ? fail_e : model_q;
   assign Dbg_state = state;

endmodule
